// File: rtl/axis_output_streamer.sv
// axis_output_streamer
//   Output-path engine: accepts one read command, emits 0..HDR_WORDS_MAX header
//   words, then streams a window of BRAM words bank-major (bank_start..bank_end,
//   addr_start..addr_start+count-1 in each bank) onto an AXI-Stream master.
//   A 2-entry output FIFO drives m_axis directly.
//   Reads are only issued when the FIFO is guaranteed to have room for the
//   returning word, so backpressure never drops data.
//
// Optional feature macro: OUTPUT_STREAMER_RELU_EN
//   defined   -> data words with MSB=1 become 0 when the latched cmd_relu_en=1
//   undefined -> data words pass through raw (cmd_relu_en ignored)
//   Header words are never modified.
//
// Ports
//   aclk, aresetn         clock, asynchronous active-low reset
//   cmd_*                 command handshake and fields (latched on accept)
//   bram_rd_en/addr       read strobe and common address for all banks
//   bram_rd_data_flat     bank b at [b*DATA_WIDTH +: DATA_WIDTH], 1 cycle after strobe
//   m_axis_*              output stream (tdata/tvalid/tready/tlast)
//   busy                  high while a command is in progress
//   done                  one-cycle pulse after the final beat is accepted
module axis_output_streamer #(
  parameter int DATA_WIDTH    = 20,
  parameter int ADDR_WIDTH    = 9,
  parameter int RD_BANKS      = 8,
  parameter int HDR_WORDS_MAX = 8,
  parameter int HDR_WIDTH     = 16,
  parameter int BW            = $clog2(RD_BANKS),
  parameter int HLW           = $clog2(HDR_WORDS_MAX + 1)
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [HLW-1:0]                     cmd_hdr_len,
  input  logic [HDR_WORDS_MAX*HDR_WIDTH-1:0] cmd_hdr_data,
  input  logic                               cmd_notify_only,
  input  logic [BW-1:0]                      cmd_bank_start,
  input  logic [BW-1:0]                      cmd_bank_end,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr_start,
  input  logic [ADDR_WIDTH:0]                cmd_addr_count,
  input  logic                               cmd_relu_en,
  output logic                               bram_rd_en,
  output logic [ADDR_WIDTH-1:0]              bram_rd_addr,
  input  logic [RD_BANKS*DATA_WIDTH-1:0]     bram_rd_data_flat,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic                               busy,
  output logic                               done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR   = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  localparam int FW = DATA_WIDTH + 1;  // {tlast, tdata}

  // ---------------- state ----------------
  logic [1:0]                       state_reg;
  logic                             ready_en_reg;
  logic                             done_reg;
  logic [HLW-1:0]                   hdr_len_reg;
  logic [HLW-1:0]                   hdr_idx_reg;
  logic [HDR_WORDS_MAX*HDR_WIDTH-1:0] hdr_data_reg;
  logic                             has_data_reg;
  logic [BW-1:0]                    bank_reg;
  logic [BW-1:0]                    bank_end_reg;
  logic [ADDR_WIDTH-1:0]            addr_start_reg;
  logic [ADDR_WIDTH:0]              addr_count_reg;
  logic [ADDR_WIDTH:0]              off_reg;
  logic                             relu_reg;
  logic                             in_flight_reg;
  logic                             rsp_last_reg;
  logic [BW-1:0]                    rsp_bank_reg;
  logic [FW-1:0]                    fifo_mem_reg [2];
  logic                             fifo_wr_ptr_reg;
  logic                             fifo_rd_ptr_reg;
  logic [1:0]                       fifo_count_reg;

  // ---------------- unpacking ----------------
  logic [HDR_WIDTH-1:0]  hdr_word  [HDR_WORDS_MAX];
  logic [DATA_WIDTH-1:0] bank_word [RD_BANKS];

  genvar gi;
  generate
    for (gi = 0; gi < HDR_WORDS_MAX; gi++) begin : g_hdr
      assign hdr_word[gi] = hdr_data_reg[gi*HDR_WIDTH +: HDR_WIDTH];
    end
    for (gi = 0; gi < RD_BANKS; gi++) begin : g_bank
      assign bank_word[gi] = bram_rd_data_flat[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // ---------------- combinational control ----------------
  logic                  pop, accept, cmd_has_data;
  logic [HLW-1:0]        cmd_len_c;
  logic [BW-1:0]         cmd_end_c;
  logic                  hdr_last_cur;
  logic [BW-1:0]         src_bank, src_end, bank_adv;
  logic [ADDR_WIDTH:0]   src_off, src_count, off_adv;
  logic [ADDR_WIDTH-1:0] src_astart;
  logic                  last_in_bank, last_read;
  logic                  hdr_push, accept_push, push_hdr, hdr_push_last;
  logic [2:0]            occ;
  logic                  credit, issue_accept, issue_hdr, issue_data, issue;
  logic [HDR_WIDTH-1:0]  hdr_sel;
  logic [DATA_WIDTH-1:0] rsp_word, rsp_word_relu;
  logic                  fifo_push;
  logic [FW-1:0]         fifo_wdata;

  assign pop          = m_axis_tvalid && m_axis_tready;
  assign accept       = cmd_valid && cmd_ready;
  assign cmd_has_data = !cmd_notify_only && (cmd_addr_count != '0);
  assign cmd_len_c    = (cmd_hdr_len > HLW'(HDR_WORDS_MAX)) ? HLW'(HDR_WORDS_MAX) : cmd_hdr_len;
  assign cmd_end_c    = (cmd_bank_end < cmd_bank_start) ? cmd_bank_start : cmd_bank_end;
  assign hdr_last_cur = (hdr_idx_reg == hdr_len_reg - 1'b1);

  // In IDLE the read cursor comes straight from the command so that a
  // command with at most one header word can issue its first read on accept.
  assign src_bank   = (state_reg == IDLE) ? cmd_bank_start : bank_reg;
  assign src_end    = (state_reg == IDLE) ? cmd_end_c      : bank_end_reg;
  assign src_off    = (state_reg == IDLE) ? '0             : off_reg;
  assign src_count  = (state_reg == IDLE) ? cmd_addr_count : addr_count_reg;
  assign src_astart = (state_reg == IDLE) ? cmd_addr_start : addr_start_reg;

  assign last_in_bank = (src_off == src_count - 1'b1);
  assign last_read    = last_in_bank && (src_bank == src_end);
  assign bank_adv     = last_in_bank ? src_bank + 1'b1 : src_bank;
  assign off_adv      = last_in_bank ? '0 : src_off + 1'b1;

  // Header word 0 is pushed on the accept edge; the rest from HDR.
  assign hdr_push      = (state_reg == HDR) && ((fifo_count_reg != 2'd2) || pop);
  assign accept_push   = accept && (cmd_len_c != '0);
  assign push_hdr      = hdr_push || accept_push;
  assign hdr_push_last = (state_reg == IDLE) ? ((cmd_len_c == HLW'(1)) && !cmd_has_data)
                                             : (hdr_last_cur && !has_data_reg);

  // Room check: words already held, words arriving this edge, minus the pop.
  // A read issued now lands one edge later, so the sum must leave one slot.
  assign occ    = 3'(fifo_count_reg) + 3'(push_hdr) + 3'(in_flight_reg) - 3'(pop);
  assign credit = (occ < 3'd2);

  assign issue_accept = accept && cmd_has_data && (cmd_len_c <= HLW'(1));
  assign issue_hdr    = hdr_push && hdr_last_cur && has_data_reg && credit;
  assign issue_data   = (state_reg == DATA) && credit;
  assign issue        = issue_accept || issue_hdr || issue_data;

  assign bram_rd_en   = issue;
  assign bram_rd_addr = issue ? (src_astart + src_off[ADDR_WIDTH-1:0]) : '0;

  always_comb begin
    hdr_sel = cmd_hdr_data[HDR_WIDTH-1:0];
    if (state_reg != IDLE) begin
      for (int i = 0; i < HDR_WORDS_MAX; i++) begin
        if (hdr_idx_reg == HLW'(i)) hdr_sel = hdr_word[i];
      end
    end
  end

  always_comb begin
    rsp_word = '0;
    for (int i = 0; i < RD_BANKS; i++) begin
      if (rsp_bank_reg == BW'(i)) rsp_word = bank_word[i];
    end
  end

`ifdef OUTPUT_STREAMER_RELU_EN
  assign rsp_word_relu = (relu_reg && rsp_word[DATA_WIDTH-1]) ? '0 : rsp_word;
`else
  logic relu_unused;
  assign relu_unused   = relu_reg;
  assign rsp_word_relu = rsp_word;
`endif

  // Header and data pushes never coincide: data only returns after the
  // last header word has been written.
  assign fifo_push  = push_hdr || in_flight_reg;
  assign fifo_wdata = in_flight_reg ? {rsp_last_reg, rsp_word_relu}
                                    : {hdr_push_last, DATA_WIDTH'(hdr_sel)};

  // ---------------- outputs ----------------
  assign m_axis_tvalid = (fifo_count_reg != 2'd0);
  assign {m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? fifo_mem_reg[fifo_rd_ptr_reg] : '0;
  assign cmd_ready = ready_en_reg && (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

  // ---------------- output FIFO ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) fifo_mem_reg[i] <= '0;
      fifo_wr_ptr_reg <= 1'b0;
      fifo_rd_ptr_reg <= 1'b0;
      fifo_count_reg  <= 2'd0;
    end else begin
      if (fifo_push) begin
        fifo_mem_reg[fifo_wr_ptr_reg] <= fifo_wdata;
        fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
      end
      if (pop) fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
      fifo_count_reg <= fifo_count_reg + 2'(fifo_push) - 2'(pop);
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg      <= IDLE;
      ready_en_reg   <= 1'b0;
      done_reg       <= 1'b0;
      hdr_len_reg    <= '0;
      hdr_idx_reg    <= '0;
      hdr_data_reg   <= '0;
      has_data_reg   <= 1'b0;
      bank_reg       <= '0;
      bank_end_reg   <= '0;
      addr_start_reg <= '0;
      addr_count_reg <= '0;
      off_reg        <= '0;
      relu_reg       <= 1'b0;
      in_flight_reg  <= 1'b0;
      rsp_last_reg   <= 1'b0;
      rsp_bank_reg   <= '0;
    end else begin
      ready_en_reg  <= 1'b1;
      done_reg      <= 1'b0;
      in_flight_reg <= issue;
      if (issue) begin
        rsp_bank_reg <= src_bank;
        rsp_last_reg <= last_read;
        bank_reg     <= bank_adv;
        off_reg      <= off_adv;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            hdr_len_reg    <= cmd_len_c;
            hdr_idx_reg    <= HLW'(1);
            hdr_data_reg   <= cmd_hdr_data;
            has_data_reg   <= cmd_has_data;
            bank_end_reg   <= cmd_end_c;
            addr_start_reg <= cmd_addr_start;
            addr_count_reg <= cmd_addr_count;
            relu_reg       <= cmd_relu_en;
            if (!issue) begin
              bank_reg <= cmd_bank_start;
              off_reg  <= '0;
            end
            if (issue_accept)              state_reg <= last_read ? DRAIN : DATA;
            else if (cmd_len_c > HLW'(1))  state_reg <= HDR;
            else                           state_reg <= DRAIN;
          end
        end
        HDR: begin
          if (hdr_push) begin
            hdr_idx_reg <= hdr_idx_reg + 1'b1;
            if (hdr_last_cur) begin
              if (!has_data_reg)               state_reg <= DRAIN;
              else if (issue_hdr && last_read) state_reg <= DRAIN;
              else                             state_reg <= DATA;
            end
          end
        end
        DATA: begin
          if (issue && last_read) state_reg <= DRAIN;
        end
        default: begin  // DRAIN
          // All reads issued: finish once the last buffered beat leaves.
          if (!in_flight_reg &&
              ((fifo_count_reg == 2'd0) || ((fifo_count_reg == 2'd1) && pop))) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_output_streamer.sv
module tb_axis_output_streamer;
  localparam int DW = 20, AW = 9, NB = 8, HM = 8, HW = 16, BW = 3, HLW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              aresetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [HLW-1:0]    cmd_hdr_len;
  logic [HM*HW-1:0]  cmd_hdr_data;
  logic              cmd_notify_only;
  logic [BW-1:0]     cmd_bank_start, cmd_bank_end;
  logic [AW-1:0]     cmd_addr_start;
  logic [AW:0]       cmd_addr_count;
  logic              cmd_relu_en;
  logic              bram_rd_en;
  logic [AW-1:0]     bram_rd_addr;
  logic [NB*DW-1:0]  bram_rd_data_flat;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic              m_axis_tlast;
  logic              busy, done;

  axis_output_streamer dut (
    .aclk(clk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_hdr_len(cmd_hdr_len), .cmd_hdr_data(cmd_hdr_data),
    .cmd_notify_only(cmd_notify_only),
    .cmd_bank_start(cmd_bank_start), .cmd_bank_end(cmd_bank_end),
    .cmd_addr_start(cmd_addr_start), .cmd_addr_count(cmd_addr_count),
    .cmd_relu_en(cmd_relu_en),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr),
    .bram_rd_data_flat(bram_rd_data_flat),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done)
  );

  typedef struct {
    int hdr_len; bit notify; int bstart; int bend;
    int astart; int acount; bit relu; int mode; int exp_beats;
  } vec_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;

  beat_t exp_q[$];
  int    exp_addr[$];
  int    addr_log[$];
  vec_t  vecs [11];

  int checks = 0, errors = 0, cyc = 0;
  int beats_seen = 0, first_hs = 0, last_hs = 0, acc_cyc = 0, done_cyc = 0, rd_cnt = 0;
  int ready_mode = 0;
  bit ready_at_done = 0;

  // BRAM model: registered read, data valid the cycle after the strobe.
  logic [DW-1:0] mem [NB][512];
  logic [DW-1:0] rd_data [NB];
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_rd
      assign bram_rd_data_flat[gi*DW +: DW] = rd_data[gi];
    end
  endgenerate

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_rd_en) begin
      for (int b = 0; b < NB; b++) rd_data[b] <= mem[b][bram_rd_addr];
      addr_log.push_back(int'(bram_rd_addr));
      rd_cnt++;
    end
  end

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, 3 stall from beat 5.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = (beats_seen < 4);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Output monitor / scoreboard.
  beat_t         mon_e;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (aresetn) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (prev_stall) begin
        checks++;
        if (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          errors++;
          $display("FAIL hold_while_stalled actual=%0h/%0b required=%0h/%0b",
                   m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat actual=%0h required=none", m_axis_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_axis_tdata !== mon_e.data || m_axis_tlast !== mon_e.last) begin
            errors++;
            $display("FAIL beat%0d actual=%0h/last%0b required=%0h/last%0b",
                     beats_seen, m_axis_tdata, m_axis_tlast, mon_e.data, mon_e.last);
          end else
            $display("beat %0d cyc %0d data=%05h last=%0b", beats_seen, cyc, m_axis_tdata, m_axis_tlast);
        end
        if (beats_seen == 0) first_hs = cyc;
        last_hs = cyc;
        beats_seen++;
      end
      if (done) begin
        done_cyc = cyc;
        ready_at_done = cmd_ready;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end else
      prev_stall = 1'b0;
  end

  function automatic int ndata(input vec_t v);
    int be = (v.bend < v.bstart) ? v.bstart : v.bend;
    return (v.notify || v.acount == 0) ? 0 : (be - v.bstart + 1) * v.acount;
  endfunction

  task automatic start_cmd(input vec_t v);
    logic [HM*HW-1:0] hd;
    beat_t nb;
    int nd, be, k, a;
    for (int i = 0; i < HM; i++) hd[i*HW +: HW] = HW'($urandom);
    nd = ndata(v);
    be = (v.bend < v.bstart) ? v.bstart : v.bend;
    for (int i = 0; i < v.hdr_len; i++) begin
      nb.data = DW'(hd[i*HW +: HW]);
      nb.last = (i == v.hdr_len - 1) && (nd == 0);
      exp_q.push_back(nb);
    end
    k = 0;
    if (nd > 0) begin
      for (int b = v.bstart; b <= be; b++) begin
        for (int j = 0; j < v.acount; j++) begin
          a = (v.astart + j) % 512;
          exp_addr.push_back(a);
          nb.data = mem[b][a];
`ifdef OUTPUT_STREAMER_RELU_EN
          if (v.relu && nb.data[DW-1]) nb.data = '0;
`endif
          k++;
          nb.last = (k == nd);
          exp_q.push_back(nb);
        end
      end
    end
    beats_seen = 0;
    rd_cnt = 0;
    addr_log.delete();
    ready_mode = v.mode;
    @(posedge clk); #1;
    cmd_valid       = 1'b1;
    cmd_hdr_len     = HLW'(v.hdr_len);
    cmd_hdr_data    = hd;
    cmd_notify_only = v.notify;
    cmd_bank_start  = BW'(v.bstart);
    cmd_bank_end    = BW'(v.bend);
    cmd_addr_start  = AW'(v.astart);
    cmd_addr_count  = (AW+1)'(v.acount);
    cmd_relu_en     = v.relu;
    begin : wait_acc
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (cmd_ready) disable wait_acc;
      end
      check("cmd_accept_timeout", 0, 1);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input vec_t v, input int idx);
    bit seen = 0;
    int nd = ndata(v);
    for (int t = 0; t < 2000 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    #1;
    check($sformatf("v%0d_done_seen", idx), seen, 1);
    check($sformatf("v%0d_beats", idx), beats_seen, v.exp_beats);
    check($sformatf("v%0d_reads", idx), rd_cnt, nd);
    check($sformatf("v%0d_ready_at_done", idx), ready_at_done, 1);
    if (v.exp_beats > 0)
      check($sformatf("v%0d_done_after_tlast", idx), done_cyc, last_hs + 1);
    else
      check($sformatf("v%0d_done_empty", idx), done_cyc, acc_cyc + 2);
    if (v.hdr_len > 0 && v.mode == 0)
      check($sformatf("v%0d_hdr0_latency", idx), first_hs, acc_cyc + 1);
    if (v.exp_beats > 0 && v.mode == 0)
      check($sformatf("v%0d_back_to_back", idx), last_hs - first_hs, v.exp_beats - 1);
    for (int i = 0; i < nd; i++) begin
      if (i < addr_log.size() && exp_addr.size() > 0)
        check($sformatf("v%0d_addr%0d", idx, i), addr_log[i], exp_addr.pop_front());
    end
    exp_addr.delete();
    $display("cmd %0d hdr=%0d beats=%0d reads=%0d done_cyc=%0d", idx, v.hdr_len, beats_seen, rd_cnt, done_cyc);
  endtask

  initial begin
    vec_t rv;
    bit   done_in_reset;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 512; a++)
        mem[b][a] = DW'((b * 7919 + a * 37 + 11) & 32'hFFFFF);
    mem[7][100] = 20'hFFFFF;
    mem[7][101] = 20'h00010;

    //           hdr nfy bs be astart cnt relu mode beats
    vecs[0]  = '{6, 0, 0, 1, 0,   4, 0, 0, 14};
    vecs[1]  = '{6, 0, 0, 1, 0,   4, 0, 1, 14};
    vecs[2]  = '{3, 1, 0, 1, 0,   4, 0, 0, 3};
    vecs[3]  = '{0, 1, 0, 0, 0,   4, 0, 0, 0};
    vecs[4]  = '{2, 0, 3, 1, 40,  3, 0, 2, 5};
    vecs[5]  = '{1, 0, 2, 2, 510, 4, 0, 0, 5};
    vecs[6]  = '{0, 0, 7, 7, 100, 2, 1, 0, 2};
    vecs[7]  = '{8, 0, 4, 7, 300, 5, 0, 2, 28};
    vecs[8]  = '{0, 0, 5, 5, 7,   1, 0, 1, 1};
    vecs[9]  = '{1, 0, 0, 7, 20,  2, 0, 0, 17};
    vecs[10] = '{4, 0, 1, 2, 0,   0, 0, 0, 4};

    aresetn = 1'b0; cmd_valid = 1'b0; cmd_hdr_len = '0; cmd_hdr_data = '0;
    cmd_notify_only = 1'b0; cmd_bank_start = '0; cmd_bank_end = '0;
    cmd_addr_start = '0; cmd_addr_count = '0; cmd_relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_rd_en", bram_rd_en, 0);
    check("rst_rd_addr", bram_rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk); #2;
    aresetn = 1'b1;
    #1 check("cmd_ready_before_first_clk", cmd_ready, 0);
    @(negedge clk);
    check("cmd_ready_after_first_clk", cmd_ready, 1);

    for (int i = 0; i < 11; i++) begin
      start_cmd(vecs[i]);
      check($sformatf("v%0d_busy", i), busy, 1);
      wait_done(vecs[i], i);
    end

    // Reset while beat 5 of 14 is stalled.
    rv = vecs[0];
    rv.mode = 3;
    start_cmd(rv);
    begin : wait_stall
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (beats_seen == 4 && m_axis_tvalid && !m_axis_tready) disable wait_stall;
      end
      check("stall_reach_timeout", 0, 1);
    end
    #2 aresetn = 1'b0;
    #1;
    check("midrst_tvalid", m_axis_tvalid, 0);
    check("midrst_tdata", m_axis_tdata, 0);
    check("midrst_tlast", m_axis_tlast, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", bram_rd_en, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    done_in_reset = 0;
    ready_mode = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_in_reset = 1;
    end
    check("midrst_no_done", done_in_reset, 0);
    exp_q.delete();
    exp_addr.delete();
    #2 aresetn = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_no_done", done, 0);
    start_cmd(vecs[0]);
    wait_done(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_output_streamer.md
# axis_output_streamer

Parametrised output-path engine for the AXI-Stream processing system. It takes one read command, emits a variable-length header, then streams a window of words from a configurable number of BRAM read banks in bank-major order. The output stage is fully backpressure-safe. It sits between the BRAM read ports and the S2MM output FIFO, and replaces the fixed 6-word header and 8-bank free-running output pipeline.

## Interface
- DATA_WIDTH, 20, stream and BRAM word width (Q9.10)
- ADDR_WIDTH, 9, BRAM address width
- RD_BANKS, 8, number of readable banks (≥2)
- HDR_WORDS_MAX, 8, maximum header words per command
- HDR_WIDTH, 16, header word width (≤ DATA_WIDTH)
- BW, $clog2(RD_BANKS), bank-index width (derived)

Clock and reset: single clock `aclk`; reset `aresetn` is asynchronous and active-low.

- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_hdr_len  in  $clog2(HDR_WORDS_MAX+1)  header words to send (0..HDR_WORDS_MAX)
- cmd_hdr_data  in  HDR_WORDS_MAX*HDR_WIDTH  header word i at [i*HDR_WIDTH +: HDR_WIDTH]
- cmd_notify_only  in  1  send header only, no data
- cmd_bank_start, cmd_bank_end  in  BW each  inclusive bank range
- cmd_addr_start  in  ADDR_WIDTH  first address in each bank
- cmd_addr_count  in  ADDR_WIDTH+1  words per bank
- cmd_relu_en  in  1  apply ReLU to data words (see Configuration)
- bram_rd_en  out  1  read strobe
- bram_rd_addr  out  ADDR_WIDTH  read address (common to all banks)
- bram_rd_data_flat  in  RD_BANKS*DATA_WIDTH  bank b at [b*DATA_WIDTH +: DATA_WIDTH], valid 1 cycle after strobe
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of command
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, HDR, DATA, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields.
  - If cmd_bank_end<cmd_bank_start, latch end=start.
  - Go to HDR if hdr_len>0, else to DATA.
  - If there are no data words (notify_only or addr_count==0), go to DRAIN instead of DATA.
- HDR: push header words 0..hdr_len-1 into the output buffer, one per cycle when space is free. Each word is zero-extended to DATA_WIDTH. ReLU is never applied to header words.
- DATA: issue reads bank-major: bank_start..bank_end, and within each bank, addresses addr_start..addr_start+count-1.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - The bank index is registered alongside each read and selects bram_rd_data_flat when the data returns.
  - After the last read is issued, go to DRAIN.
- DRAIN: wait until the buffer is empty and no read is in flight. Then pulse done and return to IDLE.
- Output buffer: 2-entry FIFO that drives m_axis directly.
  - A read is issued only if occupied + in_flight − pop < 2, so data is never dropped under backpressure.
- tlast: set on the final beat of the command, either the last data word or, if there is no data, the last header word.
  - A command with hdr_len=0 and no data emits no beats. done still pulses, 2 cycles after acceptance.
- Once m_axis_tvalid is high, tdata and tlast hold until the handshake completes.
- busy=1 from acceptance until the done pulse.

## Timing
- Reset values: cmd_ready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, bram_rd_en=0, bram_rd_addr=0, busy=0, done=0. cmd_ready rises on the first clock after reset release.
- Reset asserted mid-command clears everything asynchronously. In-flight reads and buffered words are discarded, and no done pulse is emitted.
- Header word 0 appears on m_axis the cycle after command acceptance.
- Read latency: strobe at cycle t, data enters the buffer at t+1, and is visible on m_axis at t+2.
- With m_axis_tready held high, throughput is 1 beat/cycle with no bubble between header and data, since the first read is issued during the last header cycle.
- Bank transitions cost 0 cycles.
- done pulses the cycle after the tlast handshake. cmd_ready returns high the same cycle as done.
- Total beats = hdr_len + (notify_only ? 0 : (end−start+1)·addr_count).

## Configuration
- OUTPUT_STREAMER_RELU_EN defined: a data word with MSB=1 is replaced by 0 when the latched cmd_relu_en=1. The ReLU is applied at buffer write, so it adds no latency.
- OUTPUT_STREAMER_RELU_EN undefined: cmd_relu_en is ignored and data words pass through raw. Header words are raw in both cases.

## Test plan
- Command hdr_len=6, banks 0..1, addr_start=0, count=4, tready=1 → 14 beats on consecutive cycles; tlast on beat 14; done 1 cycle later.
- Same command with tready toggling 1/0 every cycle → identical 14-word sequence; no loss or duplicate; tdata stable while stalled.
- notify_only=1, hdr_len=3 → exactly 3 beats, tlast on beat 3, bram_rd_en never asserted.
- Bank 7 returns 0xFFFFF (−1) and 0x00010 with cmd_relu_en=1 → outputs 0x00000 and 0x00010 with the macro defined, 0xFFFFF and 0x00010 without.
- addr_start=510, count=4, one bank → addresses 510, 511, 0, 1 read in that order.
- Reset asserted while beat 5 of 14 is stalled → all outputs 0 immediately, no done; a new command after release runs cleanly from header word 0.
